segasys1_viddma: RTL and testbench
==================================

SEGASYS1_VIDDMA -- requirements
Module: segasys1_viddma

Interface
REQ-001 The block SHALL have parameter ONLY_VBLK, default 1: bus cycles are issued only while VBLK=1.
REQ-002 The block SHALL have port VCLKx8, input, 1 bit: the single clock for all logic.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port VBLK, input, 1 bit: the vertical-blank window from the video block.
REQ-005 The block SHALL have ports z80_ad (input, 16), z80_wr (input, 1), z80_dw (input, 8) and z80_dr (output, 8): the Z80-side bus.
REQ-006 The block SHALL have ports cpu_ad (output, 16), cpu_wr (output, 1) and cpu_dw (output, 8): the bus driven to the video responder.
REQ-007 The block SHALL have ports cpu_rd (input, 1) and cpu_dr (input, 8) from the responder: cpu_rd is the address hit, cpu_dr is the read data.
REQ-008 The block SHALL have ports cmd_start (input, 1), cmd_op (input, 2), cmd_addr (input, 16), cmd_len (input, 12), cmd_fill (input, 8) and cmd_abort (input, 1).
REQ-009 The block SHALL have stream-in ports s_valid (input, 1), s_data (input, 8) and s_ready (output, 1).
REQ-010 The block SHALL have stream-out ports m_valid (output, 1), m_data (output, 8) and m_ready (input, 1).
REQ-011 The block SHALL have status outputs busy (1), z80_wait (1), done (1, single-cycle pulse) and err (1, sticky).

Function
REQ-012 Idle (busy=0): cpu_ad/cpu_wr/cpu_dw SHALL equal z80_ad/z80_wr/z80_dw combinationally, and z80_dr SHALL equal cpu_dr.
REQ-013 Busy: the bus SHALL be owned by the engine, z80_wait=1, and z80_wr SHALL be blocked from reaching cpu_wr.
REQ-014 cmd_start SHALL be sampled only in IDLE; a start while busy SHALL be ignored.
REQ-015 At start the block SHALL latch addr, len, op and fill; len=0 SHALL mean 4096 bytes.
REQ-016 cmd_op encoding: 00 FILL (write cmd_fill), 01 READ (bus to stream-out), 10 WRITE (stream-in to bus), 11 SHALL be treated as invalid: set err and pulse done, with no bus cycle.
REQ-017 The state machine SHALL have states IDLE, FILL, WREQ, RADDR, RWAIT, RCAP, ROUT and FIN.
REQ-018 FILL: one byte per clock SHALL be written with cpu_wr=1, cpu_ad=address and cpu_dw=fill; address increments and count decrements each write.
REQ-019 WREQ: s_ready=1 SHALL be asserted.
REQ-020 In WREQ, a byte SHALL be written only on a clock where s_valid&s_ready=1, with cpu_wr=1 that same cycle and cpu_dw=s_data.
REQ-021 READ SHALL drive cpu_ad in RADDR and hold it through RWAIT.
REQ-022 In RCAP, cpu_dr SHALL be captured, giving a two-edge read latency that matches the responder's registered RAMs.
REQ-023 If cpu_rd=0 during RCAP, the captured byte SHALL be 8'hFF and err SHALL be set.
REQ-024 ROUT SHALL hold m_valid=1 with stable m_data until m_ready=1.
REQ-025 After the ROUT handshake the block SHALL go to RADDR for the next address, or to FIN if the count is exhausted.
REQ-026 cpu_wr SHALL never be asserted in READ states.
REQ-027 The address SHALL be a 16-bit counter that wraps FFFF->0000 without error.
REQ-028 With ONLY_VBLK=1 and VBLK=0, the engine SHALL stall in place: no cpu_wr, s_ready=0, no advance.
REQ-029 The VBLK stall SHALL not affect ROUT; an in-flight RADDR/RWAIT SHALL restart at RADDR when VBLK returns.
REQ-030 FIN SHALL pulse done for one clock, then return to IDLE with busy=0 on the next clock.
REQ-031 cmd_abort in any busy state SHALL go to FIN on the next clock, suppress further bus writes, drop m_valid and s_ready, and still pulse done.
REQ-032 If cmd_abort and cmd_start arrive together in IDLE, cmd_start SHALL win and cmd_abort SHALL be ignored.
REQ-033 err SHALL clear only on reset or on an accepted cmd_start.

Reset
REQ-034 While RESET=1, the state SHALL be IDLE and busy, z80_wait, done, err, m_valid, s_ready and the internal cpu_wr drive SHALL all be 0.
REQ-035 While RESET=1, the latched address, count and data SHALL be 0.
REQ-036 A reset mid-transfer SHALL abandon the transfer immediately, with no done pulse, and pass-through SHALL resume once RESET falls.

Verification
REQ-037 The bench SHALL run: FILL addr=D800 len=4 fill=5A, VBLK=1 -> four consecutive cpu_wr pulses at D800..D803 with dw=5A, done at cycle 6, busy=0 at cycle 7.
REQ-038 The bench SHALL run: READ addr=E000 len=2 against the responder, m_ready=1 -> m_data equals the two VRAM bytes, each m_valid 3 cycles after its RADDR, err=0.
REQ-039 The bench SHALL run: READ addr=0100 len=1 (unmapped, cpu_rd=0) -> m_data=FF, err=1 held after done.
REQ-040 The bench SHALL run: WRITE addr=FFFF len=2 with s_valid gaps -> writes at FFFF then 0000, with cpu_wr asserted only on handshake cycles.
REQ-041 The bench SHALL run: FILL len=0 with ONLY_VBLK=1 and VBLK toggling -> exactly 4096 writes, all with VBLK=1, and z80_wr blocked throughout.
REQ-042 The bench SHALL run: abort during ROUT with m_ready=0 -> m_valid drops, done pulses once, and pass-through resumes.

Source files
------------

// File: rtl/segasys1_viddma.sv
// Video-bus DMA engine: shares the responder bus with the Z80 and, when started,
// fills, reads out to a stream, or writes in from a stream a block of video memory.
module segasys1_viddma #(
    parameter bit ONLY_VBLK = 1'b1
) (
    input  logic        VCLKx8,
    input  logic        RESET,
    input  logic        VBLK,

    input  logic [15:0] z80_ad,
    input  logic        z80_wr,
    input  logic [7:0]  z80_dw,
    output logic [7:0]  z80_dr,

    output logic [15:0] cpu_ad,
    output logic        cpu_wr,
    output logic [7:0]  cpu_dw,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_dr,

    input  logic        cmd_start,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [11:0] cmd_len,
    input  logic [7:0]  cmd_fill,
    input  logic        cmd_abort,

    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,

    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,

    output logic        busy,
    output logic        z80_wait,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WREQ,
        RADDR,
        RWAIT,
        RCAP,
        ROUT,
        FIN
    } state_t;

    localparam logic [1:0] OP_FILL  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    state_t      state;
    logic [15:0] addr;
    logic [12:0] cnt;
    logic [1:0]  op;
    logic [7:0]  fill;
    logic [7:0]  rdata;

    logic        stall;
    logic        last;
    logic        fill_wr;
    logic        wreq_wr;
    logic        eng_wr;

    // Outside vertical blank the engine freezes; abort also kills any write this cycle.
    assign stall   = ONLY_VBLK && !VBLK;
    assign last    = (cnt == 13'd1);
    assign busy    = (state != IDLE);
    assign z80_wait = busy;

    assign s_ready = (state == WREQ) && !stall && !cmd_abort;
    assign fill_wr = (state == FILL) && !stall && !cmd_abort;
    assign wreq_wr = s_ready && s_valid;
    assign eng_wr  = fill_wr || wreq_wr;

    assign m_valid = (state == ROUT);
    assign m_data  = rdata;

    // While busy the engine owns the bus and the Z80 write strobe never gets through.
    assign cpu_ad = busy ? addr : z80_ad;
    assign cpu_wr = busy ? eng_wr : z80_wr;
    assign cpu_dw = busy ? ((op == OP_WRITE) ? s_data : fill) : z80_dw;
    assign z80_dr = busy ? 8'hFF : cpu_dr;

    always_ff @(posedge VCLKx8 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            addr  <= 16'h0000;
            cnt   <= 13'd0;
            op    <= 2'b00;
            fill  <= 8'h00;
            rdata <= 8'h00;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        addr <= cmd_addr;
                        cnt  <= (cmd_len == 12'd0) ? 13'd4096 : {1'b0, cmd_len};
                        op   <= cmd_op;
                        fill <= cmd_fill;
                        err  <= 1'b0;
                        case (cmd_op)
                            OP_FILL:  state <= FILL;
                            OP_READ:  state <= RADDR;
                            OP_WRITE: state <= WREQ;
                            default: begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= FIN;
                            end
                        endcase
                    end
                end

                FIN: state <= IDLE;

                default: begin
                    if (cmd_abort) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        case (state)
                            FILL, WREQ: begin
                                if (eng_wr) begin
                                    addr <= addr + 16'd1;
                                    cnt  <= cnt - 13'd1;
                                    if (last) begin
                                        done  <= 1'b1;
                                        state <= FIN;
                                    end
                                end
                            end

                            RADDR: begin
                                if (!stall)
                                    state <= RWAIT;
                            end

                            // A stall here would lose the responder pipeline, so re-issue the address.
                            RWAIT: state <= stall ? RADDR : RCAP;

                            RCAP: begin
                                if (!stall) begin
                                    rdata <= cpu_rd ? cpu_dr : 8'hFF;
                                    if (!cpu_rd)
                                        err <= 1'b1;
                                    state <= ROUT;
                                end
                            end

                            ROUT: begin
                                if (m_ready) begin
                                    addr <= addr + 16'd1;
                                    cnt  <= cnt - 13'd1;
                                    if (last) begin
                                        done  <= 1'b1;
                                        state <= FIN;
                                    end else begin
                                        state <= RADDR;
                                    end
                                end
                            end

                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segasys1_viddma.sv
// Directed bench for segasys1_viddma: pass-through vector table plus hand-timed
// sequences for fill, read, write, long fill under VBLK gating, abort and reset.
module tb_segasys1_viddma;

    logic        VCLKx8 = 1'b0;
    logic        RESET;
    logic        VBLK;
    logic [15:0] z80_ad;
    logic        z80_wr;
    logic [7:0]  z80_dw;
    logic [7:0]  z80_dr;
    logic [15:0] cpu_ad;
    logic        cpu_wr;
    logic [7:0]  cpu_dw;
    logic        cpu_rd;
    logic [7:0]  cpu_dr;
    logic        cmd_start;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [11:0] cmd_len;
    logic [7:0]  cmd_fill;
    logic        cmd_abort;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        busy;
    logic        z80_wait;
    logic        done;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    segasys1_viddma #(.ONLY_VBLK(1'b1)) dut (
        .VCLKx8(VCLKx8), .RESET(RESET), .VBLK(VBLK),
        .z80_ad(z80_ad), .z80_wr(z80_wr), .z80_dw(z80_dw), .z80_dr(z80_dr),
        .cpu_ad(cpu_ad), .cpu_wr(cpu_wr), .cpu_dw(cpu_dw),
        .cpu_rd(cpu_rd), .cpu_dr(cpu_dr),
        .cmd_start(cmd_start), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_fill(cmd_fill), .cmd_abort(cmd_abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .z80_wait(z80_wait), .done(done), .err(err)
    );

    always #5 VCLKx8 = ~VCLKx8;

    // Responder: VRAM at E000-EFFF behind two register stages.
    logic [7:0] mem [0:4095];
    logic [7:0] resp_st1;
    logic [7:0] resp_dr;
    logic       use_tb_dr;
    logic [7:0] tb_dr;

    assign cpu_rd = (cpu_ad[15:12] == 4'hE);
    assign cpu_dr = use_tb_dr ? tb_dr : resp_dr;

    always @(posedge VCLKx8) begin
        resp_st1 <= mem[cpu_ad[11:0]];
        resp_dr  <= resp_st1;
    end

    logic        mon_en;
    logic [15:0] mon_base;
    logic [7:0]  mon_dw;
    int mon_wr, mon_bad_vblk, mon_bad_addr, mon_bad_dw, mon_done;

    always @(posedge VCLKx8) begin
        if (!mon_en) begin
            mon_wr = 0; mon_bad_vblk = 0; mon_bad_addr = 0; mon_bad_dw = 0; mon_done = 0;
        end else begin
            if (cpu_wr) begin
                if (!VBLK) mon_bad_vblk++;
                if (cpu_ad !== mon_base + 16'(mon_wr)) mon_bad_addr++;
                if (cpu_dw !== mon_dw) mon_bad_dw++;
                mon_wr++;
            end
            if (done) mon_done++;
        end
    end

    typedef struct {
        logic [15:0] z80_ad;
        logic        z80_wr;
        logic [7:0]  z80_dw;
        logic [7:0]  dr_in;
        logic [15:0] exp_ad;
        logic        exp_wr;
        logic [7:0]  exp_dw;
        logic [7:0]  exp_dr;
    } vec_t;

    vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge VCLKx8);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        z80_ad = v.z80_ad;
        z80_wr = v.z80_wr;
        z80_dw = v.z80_dw;
        tb_dr  = v.dr_in;
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [15:0] a,
                             input logic [11:0] len, input logic [7:0] f);
        cmd_op = op; cmd_addr = a; cmd_len = len; cmd_fill = f; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h3C;
        mem[1] = 8'hA7;

        vecs[0] = '{16'h1234, 1'b1, 8'hA5, 8'h3C, 16'h1234, 1'b1, 8'hA5, 8'h3C};
        vecs[1] = '{16'hFFFF, 1'b0, 8'h00, 8'hFF, 16'hFFFF, 1'b0, 8'h00, 8'hFF};
        vecs[2] = '{16'hD800, 1'b1, 8'h5A, 8'h81, 16'hD800, 1'b1, 8'h5A, 8'h81};
        vecs[3] = '{16'h0001, 1'b0, 8'hC3, 8'h00, 16'h0001, 1'b0, 8'hC3, 8'h00};

        RESET = 1'b1; VBLK = 1'b1; mon_en = 1'b0; mon_base = 16'h0; mon_dw = 8'h0;
        z80_ad = 16'h0; z80_wr = 1'b0; z80_dw = 8'h0;
        use_tb_dr = 1'b1; tb_dr = 8'h00;
        cmd_start = 1'b0; cmd_op = 2'b00; cmd_addr = 16'h0; cmd_len = 12'h0;
        cmd_fill = 8'h0; cmd_abort = 1'b0;
        s_valid = 1'b0; s_data = 8'h0; m_ready = 1'b0;

        step(); step();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wait", z80_wait, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_mvalid", m_valid, 1'b0);
        checkOutput("rst_sready", s_ready, 1'b0);
        checkOutput("rst_mdata", m_data, 8'h00);
        RESET = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("pt%0d_ad", i), cpu_ad, vecs[i].exp_ad);
            checkOutput($sformatf("pt%0d_wr", i), cpu_wr, vecs[i].exp_wr);
            checkOutput($sformatf("pt%0d_dw", i), cpu_dw, vecs[i].exp_dw);
            checkOutput($sformatf("pt%0d_dr", i), z80_dr, vecs[i].exp_dr);
        end
        z80_wr = 1'b0;
        use_tb_dr = 1'b0;
        step();

        // FILL D800 x4: writes in cycles 2..5, done in 6, idle in 7.
        start_cmd(2'b00, 16'hD800, 12'd4, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fill_wr%0d", i), cpu_wr, 1'b1);
            checkOutput($sformatf("fill_ad%0d", i), cpu_ad, 16'hD800 + 16'(i));
            checkOutput($sformatf("fill_dw%0d", i), cpu_dw, 8'h5A);
            checkOutput($sformatf("fill_done%0d", i), done, 1'b0);
            step();
        end
        checkOutput("fill_done", done, 1'b1);
        checkOutput("fill_fin_wr", cpu_wr, 1'b0);
        checkOutput("fill_fin_busy", busy, 1'b1);
        step();
        checkOutput("fill_idle", busy, 1'b0);
        checkOutput("fill_done_off", done, 1'b0);

        // READ E000 x2 with m_ready held high.
        m_ready = 1'b1;
        start_cmd(2'b01, 16'hE000, 12'd2, 8'h00);
        checkOutput("rd_ad0", cpu_ad, 16'hE000);
        checkOutput("rd_wait", z80_wait, 1'b1);
        step(); step();
        checkOutput("rd_nowr", cpu_wr, 1'b0);
        checkOutput("rd_mv_early", m_valid, 1'b0);
        step();
        checkOutput("rd_mv0", m_valid, 1'b1);
        checkOutput("rd_md0", m_data, 8'h3C);
        step();
        checkOutput("rd_ad1", cpu_ad, 16'hE001);
        step(); step(); step();
        checkOutput("rd_mv1", m_valid, 1'b1);
        checkOutput("rd_md1", m_data, 8'hA7);
        step();
        checkOutput("rd_done", done, 1'b1);
        checkOutput("rd_err", err, 1'b0);
        step();
        checkOutput("rd_idle", busy, 1'b0);

        // READ from unmapped 0100.
        start_cmd(2'b01, 16'h0100, 12'd1, 8'h00);
        step(); step(); step();
        checkOutput("un_mv", m_valid, 1'b1);
        checkOutput("un_md", m_data, 8'hFF);
        checkOutput("un_err", err, 1'b1);
        step();
        checkOutput("un_done", done, 1'b1);
        step(); step();
        checkOutput("un_idle", busy, 1'b0);
        checkOutput("un_err_held", err, 1'b1);
        m_ready = 1'b0;

        // WRITE FFFF x2 with stream gaps; err clears on the accepted start.
        start_cmd(2'b10, 16'hFFFF, 12'd2, 8'h00);
        checkOutput("wr_err_clr", err, 1'b0);
        checkOutput("wr_sready", s_ready, 1'b1);
        checkOutput("wr_gap0", cpu_wr, 1'b0);
        step();
        s_valid = 1'b1; s_data = 8'h11; #1;
        checkOutput("wr_wr0", cpu_wr, 1'b1);
        checkOutput("wr_ad0", cpu_ad, 16'hFFFF);
        checkOutput("wr_dw0", cpu_dw, 8'h11);
        step();
        s_valid = 1'b0; #1;
        checkOutput("wr_gap1", cpu_wr, 1'b0);
        checkOutput("wr_wrap", cpu_ad, 16'h0000);
        step();
        s_valid = 1'b1; s_data = 8'h22; #1;
        checkOutput("wr_wr1", cpu_wr, 1'b1);
        checkOutput("wr_ad1", cpu_ad, 16'h0000);
        checkOutput("wr_dw1", cpu_dw, 8'h22);
        step();
        s_valid = 1'b0; #1;
        checkOutput("wr_done", done, 1'b1);
        checkOutput("wr_sready_fin", s_ready, 1'b0);
        checkOutput("wr_err", err, 1'b0);
        step();
        checkOutput("wr_idle", busy, 1'b0);

        // Invalid op: no bus cycle, err and done.
        start_cmd(2'b11, 16'h4000, 12'd3, 8'h00);
        checkOutput("inv_done", done, 1'b1);
        checkOutput("inv_err", err, 1'b1);
        checkOutput("inv_wr", cpu_wr, 1'b0);
        step();
        checkOutput("inv_idle", busy, 1'b0);

        // Start beats abort in IDLE; a second start while busy is ignored.
        cmd_abort = 1'b1;
        cmd_op = 2'b00; cmd_addr = 16'h3000; cmd_len = 12'd2; cmd_fill = 8'h77; cmd_start = 1'b1;
        step();
        cmd_abort = 1'b0; cmd_op = 2'b01; cmd_addr = 16'h0000; #1;
        checkOutput("sa_wr0", cpu_wr, 1'b1);
        checkOutput("sa_ad0", cpu_ad, 16'h3000);
        step();
        cmd_start = 1'b0; #1;
        checkOutput("sa_ad1", cpu_ad, 16'h3001);
        checkOutput("sa_dw1", cpu_dw, 8'h77);
        step();
        checkOutput("sa_done", done, 1'b1);
        step();
        checkOutput("sa_idle", busy, 1'b0);

        // 4096-byte fill with VBLK toggling and z80_wr held high.
        mon_base = 16'h2000; mon_dw = 8'hC3; z80_wr = 1'b1;
        start_cmd(2'b00, 16'h2000, 12'd0, 8'hC3);
        mon_en = 1'b1;
        begin
            bit seen = 1'b0;
            for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
                VBLK = ((cyc % 6) < 4);
                step();
                if (done) seen = 1'b1;
            end
            checkOutput("big_timeout", seen, 1'b1);
        end
        VBLK = 1'b1;
        step();
        checkOutput("big_writes", mon_wr, 4096);
        checkOutput("big_vblk", mon_bad_vblk, 0);
        checkOutput("big_addr", mon_bad_addr, 0);
        checkOutput("big_dw", mon_bad_dw, 0);
        checkOutput("big_done_cnt", mon_done, 1);
        checkOutput("big_idle", busy, 1'b0);
        checkOutput("big_pt_wr", cpu_wr, 1'b1);
        mon_en = 1'b0; z80_wr = 1'b0;
        step();

        // Abort while ROUT waits on m_ready.
        start_cmd(2'b01, 16'hE000, 12'd3, 8'h00);
        step(); step(); step();
        checkOutput("ab_mv", m_valid, 1'b1);
        checkOutput("ab_md", m_data, 8'h3C);
        step(); step();
        checkOutput("ab_mv_hold", m_valid, 1'b1);
        checkOutput("ab_md_hold", m_data, 8'h3C);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0; #1;
        checkOutput("ab_mv_drop", m_valid, 1'b0);
        checkOutput("ab_done", done, 1'b1);
        step();
        z80_ad = 16'h1357; #1;
        checkOutput("ab_done_once", done, 1'b0);
        checkOutput("ab_idle", busy, 1'b0);
        checkOutput("ab_pt_ad", cpu_ad, 16'h1357);

        // Reset in the middle of a fill.
        start_cmd(2'b00, 16'h5000, 12'd10, 8'h99);
        step();
        RESET = 1'b1; #1;
        checkOutput("mr_busy", busy, 1'b0);
        checkOutput("mr_wr", cpu_wr, 1'b0);
        step();
        RESET = 1'b0;
        z80_ad = 16'h4321; #1;
        checkOutput("mr_pt_ad", cpu_ad, 16'h4321);
        mon_en = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checkOutput("mr_no_done", mon_done, 0);
        checkOutput("mr_idle", busy, 1'b0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
